// File: rtl/wb_write_queue.sv
// wb_write_queue
// Buffers results from two producers (port A: ALU, port B: load) in an in-order
// FIFO and drains one entry per cycle onto the single write port of the 32x64
// register file. Two combinational bypass ports return the youngest value still
// waiting to be written for a given register. Writes to X31 complete their
// handshake but are dropped.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   aValid/aReg/aData/aReady      producer A handshake (older slot on a tie)
//   bValid/bReg/bData/bReady      producer B handshake (younger slot on a tie)
//   WriteData/WriteRegister/RegWrite  registered register-file write port
//   lkReg1/2 -> lkHit1/2, lkData1/2   bypass lookups (0 data when no hit)
//   pending                       FIFO occupancy plus the staged output write
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     aValid,
  input  logic [4:0]               aReg,
  input  logic [WIDTH-1:0]         aData,
  output logic                     aReady,
  input  logic                     bValid,
  input  logic [4:0]               bReg,
  input  logic [WIDTH-1:0]         bData,
  output logic                     bReady,
  output logic [WIDTH-1:0]         WriteData,
  output logic [4:0]               WriteRegister,
  output logic                     RegWrite,
  input  logic [4:0]               lkReg1,
  input  logic [4:0]               lkReg2,
  output logic                     lkHit1,
  output logic                     lkHit2,
  output logic [WIDTH-1:0]         lkData1,
  output logic [WIDTH-1:0]         lkData2,
  output logic [$clog2(DEPTH)+1:0] pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = PW + 2;

  // FIFO storage and pointers
  logic [4:0]       reg_q  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    b_slot_s;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    free_s;

  // Output stage
  logic             reg_write_q, reg_write_d;
  logic [4:0]       wr_reg_q, wr_reg_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [NW-1:0]    pending_q, pending_d;

  logic a_push_s, b_push_s, pop_s;

  // Bypass lookup scratch, one lane per lookup port
  logic [4:0]       lk_reg_s  [2];
  logic             lk_hit_s  [2];
  logic [WIDTH-1:0] lk_data_s [2];

  // Handshake: readiness looks only at the start-of-cycle count, so a same-edge
  // pop never gives credit. B needs two free slots whenever A will enqueue.
  always_comb begin
    free_s = CW'(DEPTH) - count_q;
    aReady = (free_s >= CW'(1));
    if (aValid && (aReg != 5'd31)) begin
      bReady = (free_s >= CW'(2));
    end else begin
      bReady = (free_s >= CW'(1));
    end
    a_push_s = aValid && aReady && (aReg != 5'd31);
    b_push_s = bValid && bReady && (bReg != 5'd31);
    pop_s    = (count_q != CW'(0));
  end

  // Next-state for pointers, occupancy and the register-file output stage
  always_comb begin
    // B lands one slot after A when both enqueue on the same edge
    b_slot_s = wr_ptr_q + PW'(a_push_s);
    wr_ptr_d = wr_ptr_q + PW'(a_push_s) + PW'(b_push_s);
    rd_ptr_d = rd_ptr_q + PW'(pop_s);
    count_d  = count_q + CW'(a_push_s) + CW'(b_push_s) - CW'(pop_s);
    if (pop_s) begin
      reg_write_d = 1'b1;
      wr_reg_d    = reg_q[rd_ptr_q];
      wr_data_d   = data_q[rd_ptr_q];
    end else begin
      // Address and data hold their last value when nothing is written
      reg_write_d = 1'b0;
      wr_reg_d    = wr_reg_q;
      wr_data_d   = wr_data_q;
    end
    pending_d = NW'(count_d) + NW'(reg_write_d);
  end

  // Control and output-stage registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      reg_write_q <= 1'b0;
      wr_reg_q    <= 5'd0;
      wr_data_q   <= '0;
      pending_q   <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      pending_q   <= pending_d;
    end
  end

  // FIFO entry storage; A takes the older slot, B the younger one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= 5'd0;
        data_q[i] <= '0;
      end
    end else begin
      if (a_push_s) begin
        reg_q[wr_ptr_q]  <= aReg;
        data_q[wr_ptr_q] <= aData;
      end
      if (b_push_s) begin
        reg_q[b_slot_s]  <= bReg;
        data_q[b_slot_s] <= bData;
      end
    end
  end

  assign lk_reg_s[0] = lkReg1;
  assign lk_reg_s[1] = lkReg2;

  // Bypass: scan oldest to youngest so the tail-most match overrides; the
  // output stage is the oldest candidate. Incoming A/B data is never visible.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lk_hit_s[p]  = (reg_write_q && (wr_reg_q == lk_reg_s[p])) ? 1'b1 : 1'b0;
      lk_data_s[p] = (reg_write_q && (wr_reg_q == lk_reg_s[p])) ? wr_data_q : '0;
      for (int k = 0; k < DEPTH; k++) begin
        lk_hit_s[p]  = ((CW'(k) < count_q) && (reg_q[rd_ptr_q + PW'(k)] == lk_reg_s[p]))
                       ? 1'b1 : lk_hit_s[p];
        lk_data_s[p] = ((CW'(k) < count_q) && (reg_q[rd_ptr_q + PW'(k)] == lk_reg_s[p]))
                       ? data_q[rd_ptr_q + PW'(k)] : lk_data_s[p];
      end
      // X31 reads as zero, never as a pending write
      lk_hit_s[p]  = (lk_reg_s[p] == 5'd31) ? 1'b0 : lk_hit_s[p];
      lk_data_s[p] = (lk_reg_s[p] == 5'd31) ? '0 : lk_data_s[p];
    end
  end

  assign lkHit1        = lk_hit_s[0];
  assign lkHit2        = lk_hit_s[1];
  assign lkData1       = lk_data_s[0];
  assign lkData2       = lk_data_s[1];
  assign RegWrite      = reg_write_q;
  assign WriteRegister = wr_reg_q;
  assign WriteData     = wr_data_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;

  logic        clk;
  logic        reset_n;
  logic        aValid, bValid, aReady, bReady;
  logic [4:0]  aReg, bReg, WriteRegister, lkReg1, lkReg2;
  logic [63:0] aData, bData, WriteData, lkData1, lkData2;
  logic        RegWrite, lkHit1, lkHit2;
  logic [3:0]  pending;

  int checks;
  int errors;

  wb_write_queue #(.DEPTH(4), .WIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .aValid(aValid), .aReg(aReg), .aData(aData), .aReady(aReady),
    .bValid(bValid), .bReg(bReg), .bData(bData), .bReady(bReady),
    .WriteData(WriteData), .WriteRegister(WriteRegister), .RegWrite(RegWrite),
    .lkReg1(lkReg1), .lkReg2(lkReg2), .lkHit1(lkHit1), .lkHit2(lkHit2),
    .lkData1(lkData1), .lkData2(lkData2), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    aValid = 1'b0; aReg = 5'd0; aData = 64'h0;
    bValid = 1'b0; bReg = 5'd0; bData = 64'h0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle_inputs();
    lkReg1 = 5'd0; lkReg2 = 5'd0;
    #3;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %0h exp 0", RegWrite); end
    checks++; if (WriteRegister !== 5'd0) begin errors++; $display("FAIL reset_wreg: got %0d exp 0", WriteRegister); end
    checks++; if (WriteData !== 64'h0) begin errors++; $display("FAIL reset_wdata: got %0h exp 0", WriteData); end
    checks++; if (pending !== 4'd0) begin errors++; $display("FAIL reset_pending: got %0d exp 0", pending); end
    checks++; if (aReady !== 1'b1) begin errors++; $display("FAIL reset_aready: got %0h exp 1", aReady); end
    checks++; if (lkHit1 !== 1'b0) begin errors++; $display("FAIL reset_lkhit: got %0h exp 0", lkHit1); end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_a;
    aValid = 1'b1; aReg = 5'd5; aData = 64'h1234; lkReg1 = 5'd5;
    #1;
    checks++; if (aReady !== 1'b1) begin errors++; $display("FAIL single_aready: got %0h exp 1", aReady); end
    checks++; if (lkHit1 !== 1'b0) begin errors++; $display("FAIL single_lk_incoming: got %0h exp 0", lkHit1); end
    tick();
    idle_inputs();
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL single_c1_regwrite: got %0h exp 0", RegWrite); end
    checks++; if (pending !== 4'd1) begin errors++; $display("FAIL single_c1_pending: got %0d exp 1", pending); end
    checks++; if (lkHit1 !== 1'b1 || lkData1 !== 64'h1234) begin errors++; $display("FAIL single_c1_lookup: got hit %0h data %0h exp 1 1234", lkHit1, lkData1); end
    tick();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 64'h1234) begin errors++; $display("FAIL single_c2_write: got %0h r%0d %0h exp 1 r5 1234", RegWrite, WriteRegister, WriteData); end
    checks++; if (lkHit1 !== 1'b1 || lkData1 !== 64'h1234) begin errors++; $display("FAIL single_c2_lookup: got hit %0h data %0h exp 1 1234", lkHit1, lkData1); end
    checks++; if (pending !== 4'd1) begin errors++; $display("FAIL single_c2_pending: got %0d exp 1", pending); end
    tick();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL single_c3_regwrite: got %0h exp 0", RegWrite); end
    checks++; if (lkHit1 !== 1'b0 || lkData1 !== 64'h0) begin errors++; $display("FAIL single_c3_lookup: got hit %0h data %0h exp 0 0", lkHit1, lkData1); end
    checks++; if (WriteRegister !== 5'd5 || WriteData !== 64'h1234) begin errors++; $display("FAIL single_c3_hold: got r%0d %0h exp r5 1234", WriteRegister, WriteData); end
    checks++; if (pending !== 4'd0) begin errors++; $display("FAIL single_c3_pending: got %0d exp 0", pending); end
  endtask

  task automatic test_same_reg;
    aValid = 1'b1; aReg = 5'd3; aData = 64'hAA;
    bValid = 1'b1; bReg = 5'd3; bData = 64'hBB;
    lkReg1 = 5'd3; lkReg2 = 5'd3;
    #1;
    checks++; if (aReady !== 1'b1 || bReady !== 1'b1) begin errors++; $display("FAIL same_ready: got a%0h b%0h exp a1 b1", aReady, bReady); end
    tick();
    idle_inputs();
    #1;
    checks++; if (pending !== 4'd2) begin errors++; $display("FAIL same_c1_pending: got %0d exp 2", pending); end
    checks++; if (lkHit1 !== 1'b1 || lkData1 !== 64'hBB) begin errors++; $display("FAIL same_c1_lookup: got hit %0h data %0h exp 1 bb", lkHit1, lkData1); end
    tick();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd3 || WriteData !== 64'hAA) begin errors++; $display("FAIL same_c2_write: got %0h r%0d %0h exp 1 r3 aa", RegWrite, WriteRegister, WriteData); end
    checks++; if (lkHit2 !== 1'b1 || lkData2 !== 64'hBB) begin errors++; $display("FAIL same_c2_lookup: got hit %0h data %0h exp 1 bb", lkHit2, lkData2); end
    checks++; if (pending !== 4'd2) begin errors++; $display("FAIL same_c2_pending: got %0d exp 2", pending); end
    tick();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd3 || WriteData !== 64'hBB) begin errors++; $display("FAIL same_c3_write: got %0h r%0d %0h exp 1 r3 bb", RegWrite, WriteRegister, WriteData); end
    checks++; if (lkHit1 !== 1'b1 || lkData1 !== 64'hBB) begin errors++; $display("FAIL same_c3_lookup: got hit %0h data %0h exp 1 bb", lkHit1, lkData1); end
    tick();
    checks++; if (RegWrite !== 1'b0 || pending !== 4'd0) begin errors++; $display("FAIL same_c4_idle: got rw %0h pend %0d exp 0 0", RegWrite, pending); end
  endtask

  task automatic test_fill;
    logic [4:0]  exp_reg[$];
    logic [63:0] exp_data[$];
    int next_a, count_m, out_n;
    logic rw_m, push, pop;
    next_a = 0; count_m = 0; out_n = 0; rw_m = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      aValid = (next_a < 6);
      aReg   = 5'(next_a + 1);
      aData  = 64'h100 + 64'(next_a + 1);
      bValid = 1'b0;
      #1;
      checks++; if (aReady !== (count_m < 4)) begin errors++; $display("FAIL fill_aready cyc%0d: got %0h exp %0h", cyc, aReady, (count_m < 4)); end
      checks++; if (RegWrite !== rw_m) begin errors++; $display("FAIL fill_regwrite cyc%0d: got %0h exp %0h", cyc, RegWrite, rw_m); end
      checks++; if (pending !== 4'(count_m + int'(rw_m)) || pending > 4'd5) begin errors++; $display("FAIL fill_pending cyc%0d: got %0d exp %0d", cyc, pending, count_m + int'(rw_m)); end
      if (rw_m) begin
        checks++;
        if (WriteRegister !== exp_reg[0] || WriteData !== exp_data[0]) begin
          errors++; $display("FAIL fill_order cyc%0d: got r%0d %0h exp r%0d %0h", cyc, WriteRegister, WriteData, exp_reg[0], exp_data[0]);
        end
        void'(exp_reg.pop_front());
        void'(exp_data.pop_front());
        out_n++;
      end
      push = aValid && (count_m < 4);
      pop  = (count_m > 0);
      if (push) begin
        exp_reg.push_back(aReg);
        exp_data.push_back(aData);
        next_a++;
      end
      count_m = count_m + int'(push) - int'(pop);
      rw_m = pop;
      tick();
    end
    idle_inputs();
    checks++; if (out_n != 6 || exp_reg.size() != 0) begin errors++; $display("FAIL fill_count: got %0d writes, %0d left exp 6 0", out_n, exp_reg.size()); end
  endtask

  task automatic test_backpressure;
    logic [4:0]  er [4];
    logic [63:0] ed [4];
    er[0] = 5'd12; er[1] = 5'd13; er[2] = 5'd7;  er[3] = 5'd8;
    ed[0] = 64'hA1; ed[1] = 64'hB1; ed[2] = 64'h70; ed[3] = 64'h80;
    aValid = 1'b1; aReg = 5'd10; aData = 64'hA0;
    bValid = 1'b1; bReg = 5'd11; bData = 64'hB0;
    tick();
    aReg = 5'd12; aData = 64'hA1; bReg = 5'd13; bData = 64'hB1;
    #1;
    checks++; if (bReady !== 1'b1) begin errors++; $display("FAIL bp_c1_bready: got %0h exp 1", bReady); end
    tick();
    aReg = 5'd7; aData = 64'h70; bReg = 5'd8; bData = 64'h80;
    lkReg1 = 5'd13; lkReg2 = 5'd8;
    #1;
    checks++; if (pending !== 4'd4) begin errors++; $display("FAIL bp_c2_pending: got %0d exp 4", pending); end
    checks++; if (aReady !== 1'b1 || bReady !== 1'b0) begin errors++; $display("FAIL bp_c2_ready: got a%0h b%0h exp a1 b0", aReady, bReady); end
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd10) begin errors++; $display("FAIL bp_c2_write: got %0h r%0d exp 1 r10", RegWrite, WriteRegister); end
    checks++; if (lkHit1 !== 1'b1 || lkData1 !== 64'hB1 || lkHit2 !== 1'b0) begin errors++; $display("FAIL bp_c2_lookup: got %0h %0h %0h exp 1 b1 0", lkHit1, lkData1, lkHit2); end
    tick();
    aValid = 1'b0;
    #1;
    checks++; if (bReady !== 1'b1) begin errors++; $display("FAIL bp_c3_bready: got %0h exp 1", bReady); end
    checks++; if (WriteRegister !== 5'd11 || WriteData !== 64'hB0) begin errors++; $display("FAIL bp_c3_write: got r%0d %0h exp r11 b0", WriteRegister, WriteData); end
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (RegWrite !== 1'b1 || WriteRegister !== er[i] || WriteData !== ed[i]) begin
        errors++; $display("FAIL bp_drain%0d: got %0h r%0d %0h exp 1 r%0d %0h", i, RegWrite, WriteRegister, WriteData, er[i], ed[i]);
      end
      tick();
    end
    checks++; if (RegWrite !== 1'b0 || pending !== 4'd0) begin errors++; $display("FAIL bp_end: got rw %0h pend %0d exp 0 0", RegWrite, pending); end
  endtask

  task automatic test_x31;
    aValid = 1'b1; aReg = 5'd31; aData = 64'hFFFF;
    lkReg1 = 5'd31; lkReg2 = 5'd31;
    #1;
    checks++; if (aReady !== 1'b1) begin errors++; $display("FAIL x31_aready: got %0h exp 1", aReady); end
    tick();
    idle_inputs();
    #1;
    checks++; if (RegWrite !== 1'b0 || pending !== 4'd0) begin errors++; $display("FAIL x31_c1: got rw %0h pend %0d exp 0 0", RegWrite, pending); end
    checks++; if (lkHit1 !== 1'b0 || lkData1 !== 64'h0 || lkHit2 !== 1'b0) begin errors++; $display("FAIL x31_lookup: got %0h %0h %0h exp 0 0 0", lkHit1, lkData1, lkHit2); end
    tick();
    checks++; if (RegWrite !== 1'b0 || pending !== 4'd0) begin errors++; $display("FAIL x31_c2: got rw %0h pend %0d exp 0 0", RegWrite, pending); end
  endtask

  task automatic test_async_reset;
    aValid = 1'b1; aReg = 5'd20; aData = 64'h20;
    bValid = 1'b1; bReg = 5'd21; bData = 64'h21;
    tick();
    aReg = 5'd22; aData = 64'h22; bReg = 5'd23; bData = 64'h23;
    tick();
    idle_inputs();
    lkReg1 = 5'd23;
    #1;
    checks++; if (pending !== 4'd4 || lkHit1 !== 1'b1) begin errors++; $display("FAIL arst_pre: got pend %0d hit %0h exp 4 1", pending, lkHit1); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0 || pending !== 4'd0) begin errors++; $display("FAIL arst_now: got rw %0h pend %0d exp 0 0", RegWrite, pending); end
    checks++; if (WriteRegister !== 5'd0 || lkHit1 !== 1'b0) begin errors++; $display("FAIL arst_clear: got r%0d hit %0h exp r0 0", WriteRegister, lkHit1); end
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (RegWrite !== 1'b0 || pending !== 4'd0) begin errors++; $display("FAIL arst_stale%0d: got rw %0h pend %0d exp 0 0", i, RegWrite, pending); end
    end
    aValid = 1'b1; aReg = 5'd9; aData = 64'h99;
    tick();
    idle_inputs();
    tick();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd9 || WriteData !== 64'h99) begin errors++; $display("FAIL arst_after: got %0h r%0d %0h exp 1 r9 99", RegWrite, WriteRegister, WriteData); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_a();
    tick();
    test_same_reg();
    tick();
    test_fill();
    tick();
    test_backpressure();
    tick();
    test_x31();
    tick();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
